cache_miss_sequencer: RTL and testbench



---
 rtl/cache_miss_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_cache_miss_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_sequencer.sv
// cache_miss_sequencer: controller for a 2-way fully-associative write-back cache.
// It sequences lookup, dirty-victim writeback and refill over a fixed-latency
// synchronous RAM port behind a valid/ready request interface.
//
// Ports:
//   clock1, Reset            - clock (rising edge), synchronous active-high reset
//   req_valid/req_ready      - request handshake (req_ready = state is IDLE)
//   req_write/req_tag/req_wdata - request kind, block address, write data
//   resp_valid/resp_hit/resp_rdata - one-cycle response strobe, hit flag, data
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata - RAM port (strobes one cycle wide)
//
// Build option: define CACHE_PRESET_EN to reset with two valid demo blocks
// (way0 tag 4 data 8'h05, way1 tag 5 data 8'h03).
module cache_miss_sequencer #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clock1,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [TAG_W-1:0]  mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL_REQ, S_REFILL_WAIT, S_RESPOND
    } state_e;

    state_e                       state_q, state_d;
    logic                         write_q, write_d;
    logic [TAG_W-1:0]             rtag_q, rtag_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic                         victim_q, victim_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [1:0]                   valid_q, valid_d;
    logic [1:0]                   dirty_q, dirty_d;
    logic [1:0][TAG_W-1:0]        way_tag_q, way_tag_d;
    logic [1:0][DATA_W-1:0]       way_data_q, way_data_d;
    logic                         lru_q, lru_d;
    logic                         resp_valid_q, resp_valid_d;
    logic                         resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0]            resp_rdata_q, resp_rdata_d;
    logic [TAG_W-1:0]             mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]            mem_wdata_q, mem_wdata_d;
    logic                         mem_we_q, mem_we_d;
    logic                         mem_re_q, mem_re_d;

    logic hit0, hit1, hit_way, vic;

    // Tag compare (way0 wins duplicates) and victim choice (first invalid, else LRU)
    always_comb begin
        hit0    = valid_q[0] && (way_tag_q[0] == rtag_q);
        hit1    = valid_q[1] && (way_tag_q[1] == rtag_q);
        hit_way = !hit0;
        vic     = !valid_q[0] ? 1'b0 : (!valid_q[1] ? 1'b1 : lru_q);
    end

    // Next-state, array update and registered-output logic
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        rtag_d       = rtag_q;
        wdata_d      = wdata_q;
        victim_d     = victim_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        way_tag_d    = way_tag_q;
        way_data_d   = way_data_q;
        lru_d        = lru_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    rtag_d  = req_tag;
                    wdata_d = req_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit0 || hit1) begin
                    resp_hit_d = 1'b1;
                    if (write_q) begin
                        way_data_d[hit_way] = wdata_q;
                        dirty_d[hit_way]    = 1'b1;
                        resp_rdata_d        = wdata_q;
                    end else begin
                        resp_rdata_d = way_data_q[hit_way];
                    end
                    lru_d        = !hit_way;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESPOND;
                end else begin
                    victim_d = vic;
                    if (valid_q[vic] && dirty_q[vic]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = way_tag_q[vic];
                        mem_wdata_d = way_data_q[vic];
                        state_d     = S_WRITEBACK;
                    end else if (write_q) begin
                        // Full-word block: a write miss installs without a fetch
                        valid_d[vic]    = 1'b1;
                        dirty_d[vic]    = 1'b1;
                        way_tag_d[vic]  = rtag_q;
                        way_data_d[vic] = wdata_q;
                        lru_d           = !vic;
                        resp_hit_d      = 1'b0;
                        resp_rdata_d    = wdata_q;
                        resp_valid_d    = 1'b1;
                        state_d         = S_RESPOND;
                    end else begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = rtag_q;
                        state_d    = S_REFILL_REQ;
                    end
                end
            end
            S_WRITEBACK: begin
                if (write_q) begin
                    valid_d[victim_q]    = 1'b1;
                    dirty_d[victim_q]    = 1'b1;
                    way_tag_d[victim_q]  = rtag_q;
                    way_data_d[victim_q] = wdata_q;
                    lru_d                = !victim_q;
                    resp_hit_d           = 1'b0;
                    resp_rdata_d         = wdata_q;
                    resp_valid_d         = 1'b1;
                    state_d              = S_RESPOND;
                end else begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = rtag_q;
                    state_d    = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                // Counter reaches zero in the last wait cycle, when mem_rdata is valid
                if (cnt_q == '0) begin
                    valid_d[victim_q]    = 1'b1;
                    dirty_d[victim_q]    = 1'b0;
                    way_tag_d[victim_q]  = rtag_q;
                    way_data_d[victim_q] = mem_rdata;
                    lru_d                = !victim_q;
                    resp_hit_d           = 1'b0;
                    resp_rdata_d         = mem_rdata;
                    resp_valid_d         = 1'b1;
                    state_d              = S_RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clock1) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            rtag_q       <= '0;
            wdata_q      <= '0;
            victim_q     <= 1'b0;
            cnt_q        <= '0;
            dirty_q      <= '0;
            lru_q        <= 1'b0;
`ifdef CACHE_PRESET_EN
            valid_q       <= 2'b11;
            way_tag_q[0]  <= TAG_W'(4);
            way_tag_q[1]  <= TAG_W'(5);
            way_data_q[0] <= DATA_W'(8'h05);
            way_data_q[1] <= DATA_W'(8'h03);
`else
            valid_q      <= '0;
            way_tag_q    <= '0;
            way_data_q   <= '0;
`endif
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            rtag_q       <= rtag_d;
            wdata_q      <= wdata_d;
            victim_q     <= victim_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            way_tag_q    <= way_tag_d;
            way_data_q   <= way_data_d;
            lru_q        <= lru_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Testbench for cache_miss_sequencer: directed table, reset-abort sequence and
// randomized transactions checked against a behavioural cache/RAM model.
module tb_cache_miss_sequencer;

    localparam int unsigned TAG_W   = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MEM_LAT = 1;

    logic              clock1, Reset;
    logic              req_valid, req_ready, req_write;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid, resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic [TAG_W-1:0]  mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_rdata;

    cache_miss_sequencer #(.TAG_W(TAG_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clock1(clock1), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_tag(req_tag), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    initial clock1 = 1'b0;
    always #5 clock1 = ~clock1;

    function automatic logic [7:0] init_val(input int a);
        if (a == 3) return 8'hA7;
        if (a == 9) return 8'h3E;
        return 8'(a * 29 + 17);
    endfunction

    // RAM with one cycle read latency; contents reload on reset
    logic [7:0] ram [32];
    always @(posedge clock1) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic       wr;
        logic [4:0] tag;
        logic [7:0] wdata;
        logic       hit;
        logic [7:0] rdata;
        int         lat;
        logic       we;
        logic [4:0] we_addr;
        logic [7:0] we_data;
        logic       re;
        logic [4:0] re_addr;
        int         re_cyc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: two cache entries, LRU index, shadow RAM
    logic       mv [2];
    logic       mdirty [2];
    logic [4:0] mt [2];
    logic [7:0] mdat [2];
    int         mlru;
    logic [7:0] rmem [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rmem[i] = init_val(i);
        mlru = 0;
`ifdef CACHE_PRESET_EN
        mv[0] = 1; mdirty[0] = 0; mt[0] = 5'd4; mdat[0] = 8'h05;
        mv[1] = 1; mdirty[1] = 0; mt[1] = 5'd5; mdat[1] = 8'h03;
`else
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; mdirty[i] = 0; mt[i] = '0; mdat[i] = '0;
        end
`endif
    endtask

    task automatic model_txn(input logic wr, input logic [4:0] tag, input logic [7:0] wd,
                             output vec_t e);
        logic h0, h1, wb;
        int   w, v;
        e = '{default: 0};
        e.wr = wr; e.tag = tag; e.wdata = wd;
        h0 = mv[0] && (mt[0] == tag);
        h1 = mv[1] && (mt[1] == tag);
        if (h0 || h1) begin
            w = h0 ? 0 : 1;
            e.hit = 1;
            if (wr) begin
                mdat[w] = wd; mdirty[w] = 1; e.rdata = wd;
            end else begin
                e.rdata = mdat[w];
            end
            mlru = 1 - w;
            e.lat = 2;
        end else begin
            v  = !mv[0] ? 0 : (!mv[1] ? 1 : mlru);
            wb = mv[v] && mdirty[v];
            if (wb) begin
                e.we = 1; e.we_addr = mt[v]; e.we_data = mdat[v];
                rmem[mt[v]] = mdat[v];
            end
            if (wr) begin
                e.rdata = wd;
                e.lat = wb ? 3 : 2;
                mdat[v] = wd; mdirty[v] = 1;
            end else begin
                e.re = 1; e.re_addr = tag; e.re_cyc = wb ? 3 : 2;
                e.rdata = rmem[tag];
                e.lat = e.re_cyc + 1 + MEM_LAT;
                mdat[v] = rmem[tag]; mdirty[v] = 0;
            end
            mv[v] = 1; mt[v] = tag;
            mlru = 1 - v;
        end
    endtask

    // Observed transaction results
    int         g_lat, g_we_n, g_we_cyc, g_re_n, g_re_cyc, g_both;
    logic       g_hit;
    logic [7:0] g_rdata, g_we_data;
    logic [4:0] g_we_addr, g_re_addr;

    // Called #1 after a rising edge; that cycle is cycle 0 of the transaction
    task automatic run_txn(input logic wr, input logic [4:0] tag, input logic [7:0] wd);
        chk("ready_before_req", 32'(req_ready), 1);
        req_valid = 1; req_write = wr; req_tag = tag; req_wdata = wd;
        @(posedge clock1); #1;
        req_valid = 0; req_write = 0; req_tag = '0; req_wdata = '0;
        g_lat = 0; g_we_n = 0; g_re_n = 0; g_both = 0; g_we_cyc = 0; g_re_cyc = 0;
        g_hit = 0; g_rdata = 0; g_we_addr = 0; g_we_data = 0; g_re_addr = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (mem_we) begin
                g_we_n++; g_we_addr = mem_addr; g_we_data = mem_wdata; g_we_cyc = cyc;
            end
            if (mem_re) begin
                g_re_n++; g_re_addr = mem_addr; g_re_cyc = cyc;
            end
            if (mem_we && mem_re) g_both++;
            if (resp_valid) begin
                g_lat = cyc; g_hit = resp_hit; g_rdata = resp_rdata;
                break;
            end
            @(posedge clock1); #1;
        end
        chk("resp_seen_in_budget", 32'(g_lat != 0), 1);
        @(posedge clock1); #1;
        chk("ready_after_respond", 32'(req_ready), 1);
        chk("resp_strobe_one_cycle", 32'(resp_valid), 0);
    endtask

    task automatic check_txn(input string nm, input vec_t e);
        chk({nm, "_lat"}, 32'(g_lat), 32'(e.lat));
        chk({nm, "_hit"}, 32'(g_hit), 32'(e.hit));
        chk({nm, "_rdata"}, 32'(g_rdata), 32'(e.rdata));
        chk({nm, "_we_count"}, 32'(g_we_n), 32'(e.we));
        if (e.we) begin
            chk({nm, "_we_addr"}, 32'(g_we_addr), 32'(e.we_addr));
            chk({nm, "_we_data"}, 32'(g_we_data), 32'(e.we_data));
            chk({nm, "_we_cycle"}, 32'(g_we_cyc), 2);
        end
        chk({nm, "_re_count"}, 32'(g_re_n), 32'(e.re));
        if (e.re) begin
            chk({nm, "_re_addr"}, 32'(g_re_addr), 32'(e.re_addr));
            chk({nm, "_re_cycle"}, 32'(g_re_cyc), 32'(e.re_cyc));
        end
        chk({nm, "_we_re_overlap"}, 32'(g_both), 0);
    endtask

    task automatic do_reset();
        Reset = 1;
        @(posedge clock1); @(posedge clock1); #1;
        Reset = 0;
        model_reset();
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_hit", 32'(resp_hit), 0);
        chk("rst_resp_rdata", 32'(resp_rdata), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
    endtask

    vec_t tbl[$];
    vec_t e;
    int   seen;

    initial begin
        Reset = 1; req_valid = 0; req_write = 0; req_tag = '0; req_wdata = '0;
        mv[0] = 0; mv[1] = 0;

        // Directed table from reset (fields: wr tag wdata hit rdata lat we we_addr we_data re re_addr re_cyc)
`ifdef CACHE_PRESET_EN
        tbl.push_back('{1'b0, 5'd4, 8'h00, 1'b1, 8'h05, 2, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 0});
        tbl.push_back('{1'b0, 5'd6, 8'h00, 1'b0, 8'hBF, 4, 1'b0, 5'd0, 8'h00, 1'b1, 5'd6, 2});
`else
        tbl.push_back('{1'b0, 5'd3, 8'h00, 1'b0, 8'hA7, 4, 1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 2});
        tbl.push_back('{1'b0, 5'd3, 8'h00, 1'b1, 8'hA7, 2, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 0});
        tbl.push_back('{1'b1, 5'd7, 8'h5C, 1'b0, 8'h5C, 2, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 0});
        tbl.push_back('{1'b1, 5'd3, 8'h11, 1'b1, 8'h11, 2, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 0});
        tbl.push_back('{1'b0, 5'd9, 8'h00, 1'b0, 8'h3E, 5, 1'b1, 5'd7, 8'h5C, 1'b1, 5'd9, 3});
        tbl.push_back('{1'b0, 5'd7, 8'h00, 1'b0, 8'h5C, 5, 1'b1, 5'd3, 8'h11, 1'b1, 5'd7, 3});
`endif
        do_reset();
        foreach (tbl[i]) begin
            run_txn(tbl[i].wr, tbl[i].tag, tbl[i].wdata);
            check_txn($sformatf("tbl%0d", i), tbl[i]);
        end

        // Reset asserted during the refill wait aborts the read
        do_reset();
        req_valid = 1; req_write = 0; req_tag = 5'd20; req_wdata = '0;
        @(posedge clock1); #1;
        req_valid = 0; req_tag = '0;
        @(posedge clock1); #1;
        chk("abort_mem_re", 32'(mem_re), 1);
        chk("abort_mem_addr", 32'(mem_addr), 20);
        @(posedge clock1); #1;
        Reset = 1;
        @(posedge clock1); #1;
        Reset = 0;
        model_reset();
        chk("abort_ready", 32'(req_ready), 1);
        chk("abort_resp_valid", 32'(resp_valid), 0);
        chk("abort_mem_re_after", 32'(mem_re), 0);
        chk("abort_mem_we_after", 32'(mem_we), 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock1); #1;
            if (resp_valid || mem_re || mem_we) seen++;
        end
        chk("abort_quiet", 32'(seen), 0);
        model_txn(1'b0, 5'd20, 8'h00, e);
        run_txn(1'b0, 5'd20, 8'h00);
        check_txn("after_abort", e);

        // Randomized back-to-back traffic on a small tag set to mix hits and evictions
        do_reset();
        for (int n = 0; n < 200; n++) begin
            logic       wr;
            logic [4:0] tg;
            logic [7:0] wd;
            wr = 1'($urandom_range(0, 1));
            tg = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            wd = 8'($urandom);
            model_txn(wr, tg, wd, e);
            run_txn(wr, tg, wd);
            check_txn($sformatf("rnd%0d", n), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
